// File: rtl/cmd_pkt_pkg.sv
// Shared types and helpers for the robot command packet decoder.
// CMD_PKT_CHECKSUM_EN adds a trailing checksum word to every packet.
package cmd_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CSUM
  } state_t;

`ifdef CMD_PKT_CHECKSUM_EN
  localparam int CSUM_WORDS = 1;
`else
  localparam int CSUM_WORDS = 0;
`endif

  localparam int NUM_MOTORS = 4;
  localparam int PKT_LEN = NUM_MOTORS + 2 + CSUM_WORDS;

  function automatic longint unsigned sync_word(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/cmd_packet_decoder_if.sv
// Receive-side bus from the UART receiver: one word plus a strobe.
// master drives it (UART side), slave consumes it (decoder side).
interface cmd_packet_decoder_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input rx_data, input rx_valid);

endinterface

// File: rtl/cmd_timeout_timer.sv
// Reloadable saturating down-counter; expired holds until next reload.
// Reset behaves like a reload so the full window starts from reset.
module cmd_timeout_timer #(
  parameter int unsigned CYC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || reload) begin
      cnt <= W'(CYC - 1);
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/cmd_packet_decoder.sv
// Robot command packet decoder: sync, motor words, aux, optional checksum.
// Optional checksum word enabled by CMD_PKT_CHECKSUM_EN.
module cmd_packet_decoder
  import cmd_pkt_pkg::*;
#(
  parameter int                NUM_MOTORS = 4,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD  = DATA_W'(sync_word(DATA_W)),
  parameter int unsigned       GAP_CYC    = 50000,
  parameter int unsigned       WDOG_CYC   = 5000000
) (
  input  logic                         clk,
  input  logic                         reset,
  cmd_packet_decoder_if.slave          rx,
  output logic [NUM_MOTORS*DATA_W-1:0] motor,
  output logic [DATA_W-2:0]            kick,
  output logic                         dribbler,
  output logic                         charge_flag,
  output logic                         pkt_ok,
  output logic                         pkt_err,
  output logic                         failsafe
);

  localparam int IDX_W = $clog2(NUM_MOTORS + 2);
  localparam logic [IDX_W-1:0] AUX_IDX = IDX_W'(NUM_MOTORS);

  state_t                       state, state_nx;
  logic [IDX_W-1:0]             idx;
  logic [NUM_MOTORS*DATA_W-1:0] shadow;
  logic [DATA_W-1:0]            aux;
  logic store, commit, abort;
  logic gap_exp, wdog_exp, sync_hit;

  assign sync_hit = rx.rx_valid && (rx.rx_data == SYNC_WORD);

`ifdef CMD_PKT_CHECKSUM_EN
  logic [DATA_W-1:0] aux_q;
  logic [DATA_W-1:0] sum;
  assign aux = aux_q;
`else
  assign aux = rx.rx_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    store    = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_hit) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        if (rx.rx_valid) begin
          store = 1'b1;
          if (idx == AUX_IDX) begin
`ifdef CMD_PKT_CHECKSUM_EN
            state_nx = CSUM;
`else
            commit   = 1'b1;
            state_nx = IDLE;
`endif
          end
        end else if (gap_exp) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
`ifdef CMD_PKT_CHECKSUM_EN
      CSUM: begin
        if (rx.rx_valid) begin
          state_nx = IDLE;
          if (rx.rx_data == sum) commit = 1'b1;
          else                   abort  = 1'b1;
        end else if (gap_exp) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      shadow      <= '0;
      motor       <= '0;
      kick        <= '0;
      dribbler    <= 1'b0;
      charge_flag <= 1'b0;
      pkt_ok      <= 1'b0;
      pkt_err     <= 1'b0;
      failsafe    <= 1'b0;
`ifdef CMD_PKT_CHECKSUM_EN
      aux_q       <= '0;
      sum         <= '0;
`endif
    end else begin
      pkt_ok  <= commit;
      pkt_err <= abort;
      if (state == IDLE && sync_hit) begin
        idx <= '0;
`ifdef CMD_PKT_CHECKSUM_EN
        sum <= '0;
`endif
      end else if (store) begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
          if (idx == IDX_W'(i)) shadow[i*DATA_W +: DATA_W] <= rx.rx_data;
        end
        idx <= idx + 1'b1;
`ifdef CMD_PKT_CHECKSUM_EN
        if (idx == AUX_IDX) aux_q <= rx.rx_data;
        sum <= sum + rx.rx_data;
`endif
      end
      // A commit in the same cycle as watchdog expiry takes priority.
      if (commit) begin
        motor       <= shadow;
        kick        <= aux[DATA_W-2:0];
        dribbler    <= aux[DATA_W-1];
        charge_flag <= (aux[DATA_W-2:0] != '0);
        failsafe    <= 1'b0;
      end else if (wdog_exp) begin
        motor       <= '0;
        kick        <= '0;
        dribbler    <= 1'b0;
        charge_flag <= 1'b0;
        failsafe    <= 1'b1;
      end
    end
  end

  cmd_timeout_timer #(.CYC(GAP_CYC)) u_gap (
    .clk     (clk),
    .reset   (reset),
    .reload  (rx.rx_valid),
    .enable  (state != IDLE),
    .expired (gap_exp)
  );

  if (WDOG_CYC > 0) begin : g_wdog
    cmd_timeout_timer #(.CYC(WDOG_CYC)) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .reload  (commit),
      .enable  (1'b1),
      .expired (wdog_exp)
    );
  end else begin : g_no_wdog
    assign wdog_exp = 1'b0;
  end

endmodule

// File: tb/tb_cmd_packet_decoder.sv
// Scoreboard bench for cmd_packet_decoder (small gap/watchdog windows).
// Honours CMD_PKT_CHECKSUM_EN by appending checksum words.
module tb_cmd_packet_decoder;

  localparam int NM   = 4;
  localparam int DW   = 8;
  localparam int GAP  = 20;
  localparam int WDOG = 300;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    bit          ok;
    logic [31:0] m;
    logic [6:0]  k;
    logic        d;
    logic        c;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NM*DW-1:0] motor;
  logic [DW-2:0]   kick;
  logic            dribbler, charge_flag, pkt_ok, pkt_err, failsafe;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t cur;
  exp_t e_mon;

  cmd_packet_decoder_if #(.DATA_W(DW)) rx_if ();

  cmd_packet_decoder #(
    .NUM_MOTORS (NM),
    .DATA_W     (DW),
    .SYNC_WORD  (8'hFF),
    .GAP_CYC    (GAP),
    .WDOG_CYC   (WDOG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx_if),
    .motor       (motor),
    .kick        (kick),
    .dribbler    (dribbler),
    .charge_flag (charge_flag),
    .pkt_ok      (pkt_ok),
    .pkt_err     (pkt_err),
    .failsafe    (failsafe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (pkt_ok && pkt_err) check("ok_err_excl", 1, 0);
      if (pkt_ok || pkt_err) begin
        if (sb.size() == 0) begin
          check("unexpected_evt", {pkt_ok, pkt_err}, 0);
        end else begin
          e_mon = sb.pop_front();
          check("evt_ok", pkt_ok, e_mon.ok);
          check("motor", motor, e_mon.m);
          check("kick", kick, e_mon.k);
          check("dribbler", dribbler, e_mon.d);
          check("charge_flag", charge_flag, e_mon.c);
          if (e_mon.ok) check("failsafe_clr", failsafe, 0);
        end
      end
    end
  end

  task automatic send(input byte_q_t q, input int idle);
    foreach (q[i]) begin
      @(negedge clk);
      rx_if.rx_data  = q[i];
      rx_if.rx_valid = 1'b1;
      if (idle > 0) begin
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
        repeat (idle - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic good_pkt(input logic [7:0] m0, m1, m2, m3, a,
                          input int idle);
    byte_q_t q;
    exp_t    e;
    q = '{8'hFF, m0, m1, m2, m3, a};
`ifdef CMD_PKT_CHECKSUM_EN
    q.push_back(m0 + m1 + m2 + m3 + a);
`endif
    e.ok = 1'b1;
    e.m  = {m3, m2, m1, m0};
    e.k  = a[6:0];
    e.d  = a[7];
    e.c  = (a[6:0] != 7'd0);
    cur  = e;
    sb.push_back(e);
    send(q, idle);
  endtask

  task automatic push_err();
    exp_t e;
    e    = cur;
    e.ok = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int lim);
    int n;
    n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_motor"}, motor, 0);
    check({tag, "_kick"}, kick, 0);
    check({tag, "_drib"}, dribbler, 0);
    check({tag, "_chg"}, charge_flag, 0);
    check({tag, "_ok"}, pkt_ok, 0);
    check({tag, "_err"}, pkt_err, 0);
    check({tag, "_fs"}, failsafe, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t q;
    cur = '{ok: 1'b0, m: '0, k: '0, d: 1'b0, c: 1'b0};
    rx_if.rx_data  = '0;
    rx_if.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    good_pkt(8'h10, 8'h20, 8'h30, 8'h40, 8'h85, 0);
    wait_drain("drain_basic", 10);

    q = '{8'hFF, 8'h01, 8'h02};
    push_err();
    send(q, 0);
    wait_drain("drain_gap", GAP + 10);
    check("gap_hold_motor", motor, 32'h40302010);
    good_pkt(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 0);
    wait_drain("drain_after_gap", 10);

    good_pkt(8'h5A, 8'hFF, 8'h00, 8'hA5, 8'h80, GAP - 1);
    wait_drain("drain_slow", 10);

    q = '{8'h3A};
    send(q, 0);
    good_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 0);
    wait_drain("drain_lead", 10);

`ifdef CMD_PKT_CHECKSUM_EN
    good_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 0);
    wait_drain("drain_csum_ok", 10);
    q = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0E};
    push_err();
    send(q, 0);
    wait_drain("drain_csum_bad", 10);
`endif

    good_pkt(8'h21, 8'h43, 8'h65, 8'h87, 8'h7F, 0);
    repeat (WDOG - 1) @(negedge clk);
    check("wdog_not_yet", failsafe, 0);
    check("sb_wdog", sb.size(), 0);
    @(negedge clk);
    check("wdog_fs", failsafe, 1);
    check("wdog_motor", motor, 0);
    check("wdog_kick", kick, 0);
    check("wdog_chg", charge_flag, 0);
    cur = '{ok: 1'b0, m: '0, k: '0, d: 1'b0, c: 1'b0};
    good_pkt(8'h09, 8'h08, 8'h07, 8'h06, 8'h03, 0);
    wait_drain("drain_wdog_clr", 10);

    q = '{8'hFF, 8'h11};
    send(q, 0);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    reset = 1'b0;
    cur = '{ok: 1'b0, m: '0, k: '0, d: 1'b0, c: 1'b0};
    good_pkt(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h81, 0);
    wait_drain("drain_post_rst", 10);

    repeat (5) @(negedge clk);
    check("sb_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
